key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Consumes the debounced edge pulses and level from the key debouncer. The key is active-low, idle high; a press is a falling edge.
- Classifies each gesture as short press, long press or double click.
- Emits one-cycle event strobes to the control/menu logic.
- Sits directly downstream of the debouncer, one instance per key.

Parameters:
- N, 32, timer bitwidth.
- FREQ, 100, clock frequency in MHz.
- LONG_MS, 1000, hold time that qualifies a long press.
- DCLICK_MS, 300, maximum release-to-second-press gap for a double click.
- REPEAT_MS, 200, auto-repeat period while held long (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_press  input  1  one-cycle pulse on debounced falling edge (press).
- key_release  input  1  one-cycle pulse on debounced rising edge (release).
- key_level  input  1  debounced level, 0 = pressed.
- short_press  output  1  one-cycle strobe.
- long_press  output  1  one-cycle strobe.
- double_click  output  1  one-cycle strobe.
- repeat_pulse  output  1  one-cycle strobe; tied 0 without the optional feature.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. During reset the FSM goes to IDLE, the timer clears, and all outputs are 0.
- Tick constants, computed in N bits, must be at least 1:
  - LONG_TICKS = LONG_MS*1000*FREQ
  - DCLICK_TICKS = DCLICK_MS*1000*FREQ
  - REPEAT_TICKS = REPEAT_MS*1000*FREQ
- Timer:
  - Clears on every state change.
  - Otherwise increments each cycle.
  - Saturates at all-ones and never wraps.
- All outputs are registered. A strobe is high exactly one cycle, in the cycle after the deciding event or timeout.
- States and transitions:
  - IDLE:
    - key_press goes to PRESS1.
    - key_release is ignored.
  - PRESS1:
    - key_release with timer < LONG_TICKS-1 goes to WAIT2.
    - timer == LONG_TICKS-1 pulses long_press and goes to LONG_HOLD.
  - WAIT2:
    - key_press with timer < DCLICK_TICKS-1 goes to PRESS2.
    - timer == DCLICK_TICKS-1 pulses short_press and goes to IDLE.
  - PRESS2:
    - key_release pulses double_click and goes to IDLE.
    - timer == LONG_TICKS-1 pulses long_press and goes to LONG_HOLD; the first click is discarded, so no short_press is issued.
  - LONG_HOLD:
    - key_release goes to IDLE; no further strobes.
- Boundary conditions:
  - key_press and key_release asserted in the same cycle: both are ignored and state is unchanged.
  - Release in the same cycle the long timeout fires in PRESS1 or PRESS2: the timeout wins (long_press); the release is then processed in LONG_HOLD and returns the FSM to IDLE.
  - Press in the same cycle the WAIT2 timeout fires: the timeout wins (short_press, go to IDLE); that press is lost.
  - Consistency check: in any press-holding state, if key_level==1 while no key_release is seen, the FSM returns to IDLE with no strobe. This guards against missed edges.
  - At most one strobe is high in any cycle.
- Reset mid-gesture: outputs clear immediately, the FSM goes to IDLE, and the next gesture begins with a fresh key_press.

Optional Feature:
- Macro: KEY_EVENT_REPEAT_EN.
- Defined:
  - In LONG_HOLD, the timer restarts after each expiry.
  - repeat_pulse strobes every REPEAT_TICKS cycles until release.
  - The first repeat_pulse comes REPEAT_TICKS cycles after the long_press strobe.
- Undefined:
  - repeat_pulse is constant 0.
  - LONG_HOLD does not count and only waits for release.

Decomposition:
- Shared package key_event_pkg holds:
  - the state enum {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD};
  - the ms-to-ticks constant function.
- One sub-module, key_tick_timer:
  - N-bit saturating up-counter with synchronous clear;
  - outputs the count.
- The decoder FSM instantiates key_tick_timer once.

Test Plan (FREQ=1, LONG_MS=2, DCLICK_MS=1, REPEAT_MS=1, which gives LONG=2000, DCLICK=1000, REPEAT=1000 ticks):
- Press, release after 500 cycles, no further press → short_press high one cycle, 1000 cycles after release; busy falls the same cycle.
- Press, release at 300, press again 400 cycles later, release after 200 → double_click one cycle after the second release; no short_press.
- Press held 2500 cycles → long_press 2000 cycles after the press; nothing on release. With KEY_EVENT_REPEAT_EN, repeat_pulse fires 1000 cycles after long_press; without it, repeat_pulse stays 0.
- key_press and key_release in the same cycle while IDLE → no state change, busy stays 0; release alone in IDLE → ignored.
- Press, then assert rst_n=0 at cycle 100 for 3 cycles → all outputs 0 and busy 0 during reset; the next press/release sequence produces a correct short_press.
- Press, release exactly when timer==1999 → long_press (not short_press); FSM is IDLE after the following cycle.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event decoder.
// Used by key_tick_timer and key_event_decoder.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD
  } state_t;

  typedef struct packed {
    logic short_p;
    logic long_p;
    logic dbl;
    logic rep;
  } ev_t;

  // Raw tick count; the caller narrows it to its timer width.
  function automatic logic [63:0] ms_to_ticks(
    input int unsigned ms,
    input int unsigned mhz
  );
    logic [63:0] t;
    t = 64'(ms) * 64'd1000 * 64'(mhz);
    return t;
  endfunction

endpackage

// File: rtl/key_tick_timer.sv
// N-bit saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
import key_event_pkg::*;

module key_tick_timer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic [N-1:0] count
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Short / long / double-click classifier for one debounced key.
// Define KEY_EVENT_REPEAT_EN for auto-repeat while held long.
import key_event_pkg::*;

module key_event_decoder #(
  parameter int unsigned N         = 32,
  parameter int unsigned FREQ      = 100,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_press,
  input  logic key_release,
  input  logic key_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] fit(input logic [63:0] raw);
    logic [N-1:0] t;
    t = raw[N-1:0];
    return (t == '0) ? ONE : t;
  endfunction

  localparam logic [N-1:0] LONG_T =
    fit(ms_to_ticks(LONG_MS, FREQ));
  localparam logic [N-1:0] DCL_T =
    fit(ms_to_ticks(DCLICK_MS, FREQ));
  localparam logic [N-1:0] REP_T =
    fit(ms_to_ticks(REPEAT_MS, FREQ));

  localparam logic [N-1:0] LONG_M1 = LONG_T - ONE;
  localparam logic [N-1:0] DCL_M1  = DCL_T - ONE;
  localparam logic [N-1:0] REP_M1  = REP_T - ONE;

`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  state_t       state;
  state_t       nxt;
  ev_t          ev;
  logic [N-1:0] cnt;
  logic         clr;
  logic         both;
  logic         press;
  logic         rel;

  // Coincident edges cancel each other out.
  assign both  = key_press & key_release;
  assign press = key_press & ~key_release;
  assign rel   = key_release & ~key_press;

  key_tick_timer #(
    .N (N)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .count (cnt)
  );

  always_comb begin
    nxt = state;
    ev  = '0;
    unique case (state)
      IDLE: begin
        if (press) nxt = PRESS1;
      end
      PRESS1: begin
        if (cnt == LONG_M1) begin
          nxt       = LONG_HOLD;
          ev.long_p = 1'b1;
        end else if (rel) begin
          nxt = WAIT2;
        end else if (!both && key_level) begin
          nxt = IDLE;
        end
      end
      WAIT2: begin
        if (cnt == DCL_M1) begin
          nxt        = IDLE;
          ev.short_p = 1'b1;
        end else if (press) begin
          nxt = PRESS2;
        end
      end
      PRESS2: begin
        if (cnt == LONG_M1) begin
          nxt       = LONG_HOLD;
          ev.long_p = 1'b1;
        end else if (rel) begin
          nxt    = IDLE;
          ev.dbl = 1'b1;
        end else if (!both && key_level) begin
          nxt = IDLE;
        end
      end
      LONG_HOLD: begin
        // A release lost to the long timeout shows up here as a high level.
        if (rel || (!both && key_level)) begin
          nxt = IDLE;
        end else if (REP_EN && cnt == REP_M1) begin
          ev.rep = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign clr  = (nxt != state) | ev.rep;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= nxt;
      short_press  <= ev.short_p;
      long_press   <= ev.long_p;
      double_click <= ev.dbl;
      repeat_pulse <= ev.rep;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed gesture bench for key_event_decoder.
// Expected events come from gesture timing arithmetic.
module tb_key_event_decoder;

  localparam int FREQ   = 1;
  localparam int LMS    = 2;
  localparam int DMS    = 1;
  localparam int RMS    = 1;
  localparam int LONG_T = LMS * 1000 * FREQ;
  localparam int DCL_T  = DMS * 1000 * FREQ;
  localparam int REP_T  = RMS * 1000 * FREQ;

  localparam int E_SHORT = 1;
  localparam int E_LONG  = 2;
  localparam int E_DBL   = 3;
  localparam int E_REP   = 4;

  typedef struct {
    int typ;
    int cyc;
    int bsy;
  } ev_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_press = 1'b0;
  logic key_release = 1'b0;
  logic key_level = 1'b1;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_pulse;
  logic busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mon_n;
  int mon_t;
  ev_rec_t obs_q[$];
  ev_rec_t exp_q[$];

  key_event_decoder #(
    .N         (32),
    .FREQ      (FREQ),
    .LONG_MS   (LMS),
    .DCLICK_MS (DMS),
    .REPEAT_MS (RMS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_level    (key_level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    mon_n = $countones({short_press, long_press,
                        double_click, repeat_pulse});
    if (mon_n != 0) begin
      check("one_strobe", mon_n, 1);
      mon_t = short_press ? E_SHORT :
              long_press  ? E_LONG  :
              double_click ? E_DBL  : E_REP;
      obs_q.push_back('{typ: mon_t, cyc: cyc, bsy: int'(busy)});
    end
  end

  task automatic press_pulse();
    key_press = 1'b1;
    key_level = 1'b0;
    @(negedge clk);
    key_press = 1'b0;
  endtask

  task automatic release_pulse();
    key_release = 1'b1;
    key_level = 1'b1;
    @(negedge clk);
    key_release = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_sp"}, int'(short_press), 0);
    check({tag, "_lp"}, int'(long_press), 0);
    check({tag, "_dc"}, int'(double_click), 0);
    check({tag, "_rp"}, int'(repeat_pulse), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Long press fired at start+LONG_T; repeats follow every REP_T until release.
  task automatic exp_long(input int start, input int rel);
    int l;
    l = start + LONG_T;
    exp_q.push_back('{typ: E_LONG, cyc: l, bsy: 1});
`ifdef KEY_EVENT_REPEAT_EN
    for (int e = l + REP_T; e < rel; e += REP_T)
      exp_q.push_back('{typ: E_REP, cyc: e, bsy: 1});
`endif
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_type"}, obs_q[i].typ, exp_q[i].typ);
      check({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      check({tag, "_busy_at"}, obs_q[i].bsy, exp_q[i].bsy);
    end
  endtask

  task automatic gesture(input string tag, input int h,
                         input bit second, input int g, input int h2);
    int p;
    int r;
    int q;
    obs_q.delete();
    exp_q.delete();
    p = cyc + 1;
    press_pulse();
    repeat (h - 1) @(negedge clk);
    release_pulse();
    r = p + h;
    if (h == LONG_T) begin
      @(negedge clk);
      check({tag, "_idle_next"}, int'(busy), 0);
    end
    q = 0;
    if (second) begin
      repeat (g - 1) @(negedge clk);
      q = cyc + 1;
      press_pulse();
      repeat (h2 - 1) @(negedge clk);
      release_pulse();
    end
    wait_idle(tag);
    repeat (4) @(negedge clk);
    if (h >= LONG_T) begin
      exp_long(p, r);
    end else if (!second || g >= DCL_T) begin
      exp_q.push_back('{typ: E_SHORT, cyc: r + DCL_T, bsy: 0});
    end else if (h2 >= LONG_T) begin
      exp_long(q, q + h2);
    end else begin
      exp_q.push_back('{typ: E_DBL, cyc: q + h2, bsy: 0});
    end
    compare(tag);
  endtask

  initial begin
    int kind;
    int h;
    int g;
    int h2;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outs_zero("post_reset");

    gesture("short", 500, 1'b0, 0, 0);
    gesture("double", 300, 1'b1, 400, 200);
    gesture("long", 2500, 1'b0, 0, 0);
    gesture("long_edge", LONG_T, 1'b0, 0, 0);
    gesture("wait2_edge", 700, 1'b1, DCL_T, 50);
    gesture("press2_long", 100, 1'b1, 200, 2300);

    obs_q.delete();
    key_press = 1'b1;
    key_release = 1'b1;
    @(negedge clk);
    key_press = 1'b0;
    key_release = 1'b0;
    @(negedge clk);
    check("both_idle_busy", int'(busy), 0);
    release_pulse();
    @(negedge clk);
    check("rel_idle_busy", int'(busy), 0);
    check("idle_no_events", obs_q.size(), 0);

    press_pulse();
    repeat (50) @(negedge clk);
    check("consist_busy_pre", int'(busy), 1);
    key_level = 1'b1;
    repeat (2) @(negedge clk);
    check("consist_busy", int'(busy), 0);
    repeat (2100) @(negedge clk);
    check("consist_no_events", obs_q.size(), 0);

    press_pulse();
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs_zero("mid_reset");
    repeat (3) begin
      @(negedge clk);
      check_outs_zero("in_reset");
    end
    key_level = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    gesture("rst_short", 500, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      kind = int'($urandom_range(0, 3));
      h = int'($urandom_range(1, LONG_T - 1));
      g = ($urandom_range(0, 4) == 0) ? DCL_T
                                      : int'($urandom_range(1, DCL_T - 1));
      h2 = int'($urandom_range(1, LONG_T - 1));
      case (kind)
        0: gesture("rnd_short", h, 1'b0, 0, 0);
        1: gesture("rnd_double", h, 1'b1, g, h2);
        2: gesture("rnd_long", int'($urandom_range(LONG_T, 3600)),
                   1'b0, 0, 0);
        default: gesture("rnd_p2long", h, 1'b1, g,
                         int'($urandom_range(LONG_T, 3600)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
